// File: rtl/brake_light_sequencer.sv
// Brake-lamp duty sequencer: brake/hold, emergency flash on hard-brake onset, hazard
// flashing in idle, and a dimmed tail level with the headlight on. Outputs are registered.
module brake_light_sequencer #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned FLASH_TICKS = 100,
  parameter int unsigned FLASH_COUNT = 4,
  parameter int unsigned HOLD_TICKS  = 200,
  parameter int unsigned HAZ_TICKS   = 500,
  parameter logic [9:0]  DUTY_FULL   = 10'h3FF,
  parameter logic [9:0]  DUTY_TAIL   = 10'h01F
) (
  input  logic       c50M,
  input  logic       reset_n,
  input  logic       brakeActive,
  input  logic       hardBrake,
  input  logic       headLightActive,
  input  logic       hazardActive,
  output logic [9:0] PWMinput,
  output logic       flashing,
  output logic [2:0] lampState
);
  localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PH_LIM = (FLASH_TICKS > HOLD_TICKS) ? FLASH_TICKS : HOLD_TICKS;
  localparam int unsigned PH_W   = $clog2(PH_LIM + 1);
  localparam int unsigned HZ_W   = $clog2(HAZ_TICKS + 1);
  localparam int unsigned FC_W   = $clog2(FLASH_COUNT + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_FLASH = PH_W'(FLASH_TICKS);
  localparam logic [PH_W-1:0]  PH_HOLD  = PH_W'(HOLD_TICKS);
  localparam logic [HZ_W-1:0]  HZ_LIM   = HZ_W'(HAZ_TICKS);
  localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLASH_COUNT);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BRAKE      = 3'd1,
    S_EFLASH_ON  = 3'd2,
    S_EFLASH_OFF = 3'd3,
    S_HOLD       = 3'd4
  } state_t;

  logic [PRE_W-1:0] r_presc;
  logic             w_tick;
  state_t           r_state, w_state_next;
  logic [PH_W-1:0]  r_phase, w_phase_next, w_phase_inc;
  logic [FC_W-1:0]  r_flash_cnt, w_flash_next, w_flash_dec;
  logic             r_armed, w_armed_next;
  logic [HZ_W-1:0]  r_haz_cnt, w_haz_cnt_next, w_haz_inc;
  logic             r_haz_phase, w_haz_phase_next;
  logic [9:0]       w_base, w_duty_next;
  logic             w_timed;
  logic [9:0]       r_pwm;
  logic             r_flashing;
  logic [2:0]       r_lamp_state;

  assign w_tick      = (r_presc == PRE_LAST);
  assign w_phase_inc = r_phase + PH_W'(1);
  assign w_flash_dec = r_flash_cnt - FC_W'(1);
  assign w_haz_inc   = r_haz_cnt + HZ_W'(1);
  assign w_base      = headLightActive ? DUTY_TAIL : 10'h000;
  assign w_timed     = (r_state == S_EFLASH_ON) || (r_state == S_EFLASH_OFF) || (r_state == S_HOLD);

  always_ff @(posedge c50M or negedge reset_n) begin
    if (!reset_n) r_presc <= '0;
    else          r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
  end

  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_flash_next     = r_flash_cnt;
    w_armed_next     = r_armed;
    w_haz_cnt_next   = '0;
    w_haz_phase_next = 1'b0;
    w_duty_next      = DUTY_FULL;
    case (r_state)
      S_IDLE: begin
        w_armed_next = 1'b1;
        if (brakeActive && hardBrake) begin
          w_state_next = S_EFLASH_ON;
          w_flash_next = FC_LOAD;
          w_armed_next = 1'b0;
        end else if (brakeActive) begin
          w_state_next = S_BRAKE;
        end
      end
      S_BRAKE: begin
        if (hardBrake && r_armed) begin
          w_state_next = S_EFLASH_ON;
          w_flash_next = FC_LOAD;
          w_armed_next = 1'b0;
        end else if (!brakeActive) begin
          w_state_next = S_HOLD;
        end
      end
      S_EFLASH_ON: begin
        if (w_tick && w_phase_inc == PH_FLASH) w_state_next = S_EFLASH_OFF;
      end
      S_EFLASH_OFF: begin
        // The sequence runs to completion even if the pedal is released mid-flash.
        if (w_tick && w_phase_inc == PH_FLASH) begin
          w_flash_next = w_flash_dec;
          if (w_flash_dec == '0) w_state_next = brakeActive ? S_BRAKE : S_IDLE;
          else                   w_state_next = S_EFLASH_ON;
        end
      end
      S_HOLD: begin
        if (brakeActive)                            w_state_next = S_BRAKE;
        else if (w_tick && w_phase_inc == PH_HOLD) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_state_next != r_state)  w_phase_next = '0;
    else if (w_tick && w_timed)   w_phase_next = w_phase_inc;

    if (r_state == S_IDLE && w_state_next == S_IDLE && hazardActive) begin
      w_haz_cnt_next   = r_haz_cnt;
      w_haz_phase_next = r_haz_phase;
      if (w_tick) begin
        if (w_haz_inc == HZ_LIM) begin
          w_haz_cnt_next   = '0;
          w_haz_phase_next = ~r_haz_phase;
        end else begin
          w_haz_cnt_next = w_haz_inc;
        end
      end
    end

    case (w_state_next)
      S_IDLE:       w_duty_next = w_haz_phase_next ? DUTY_FULL : w_base;
      S_EFLASH_OFF: w_duty_next = 10'h000;
      default:      w_duty_next = DUTY_FULL;
    endcase
  end

  // Outputs are registered from the next-state decode so they track r_state exactly.
  always_ff @(posedge c50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_flash_cnt  <= '0;
      r_armed      <= 1'b0;
      r_haz_cnt    <= '0;
      r_haz_phase  <= 1'b0;
      r_pwm        <= 10'h000;
      r_flashing   <= 1'b0;
      r_lamp_state <= 3'd0;
    end else begin
      r_state      <= w_state_next;
      r_phase      <= w_phase_next;
      r_flash_cnt  <= w_flash_next;
      r_armed      <= w_armed_next;
      r_haz_cnt    <= w_haz_cnt_next;
      r_haz_phase  <= w_haz_phase_next;
      r_pwm        <= w_duty_next;
      r_flashing   <= (w_state_next == S_EFLASH_ON) || (w_state_next == S_EFLASH_OFF);
      r_lamp_state <= w_state_next;
    end
  end

  assign PWMinput  = r_pwm;
  assign flashing  = r_flashing;
  assign lampState = r_lamp_state;
endmodule

// File: tb/tb_brake_light_sequencer.sv
// Scenario tasks plus randomized traffic, all checked against a tick-timestamp model.
`timescale 1ns/1ps
module tb_brake_light_sequencer;
  localparam int DIV = 10, FT = 2, FC = 2, HT = 3, HZT = 4;
  localparam logic [9:0] FULL = 10'h3FF, TAIL = 10'h01F;

  logic c50M = 1'b0, reset_n = 1'b1;
  logic brakeActive = 1'b0, hardBrake = 1'b0, headLightActive = 1'b0, hazardActive = 1'b0;
  logic [9:0] PWMinput;
  logic       flashing;
  logic [2:0] lampState;
  int checks = 0, errors = 0;

  // Model: mode number, absolute tick count, entry tick stamp, remaining flash half-periods.
  int m_mode, m_cyc, m_ticks, m_entry, m_left, m_haz;
  bit m_armed;
  logic [9:0] m_pwm;
  logic       m_flash;
  logic [2:0] m_state;

  brake_light_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .FLASH_TICKS(FT), .FLASH_COUNT(FC),
    .HOLD_TICKS(HT), .HAZ_TICKS(HZT), .DUTY_FULL(FULL), .DUTY_TAIL(TAIL)
  ) dut (
    .c50M(c50M), .reset_n(reset_n), .brakeActive(brakeActive), .hardBrake(hardBrake),
    .headLightActive(headLightActive), .hazardActive(hazardActive),
    .PWMinput(PWMinput), .flashing(flashing), .lampState(lampState)
  );

  always #5 c50M = ~c50M;

  task automatic model_reset();
    m_mode = 0; m_cyc = 0; m_ticks = 0; m_entry = 0; m_left = 0; m_haz = 0; m_armed = 0;
    m_pwm = 10'h000; m_flash = 1'b0; m_state = 3'd0;
  endtask

  task automatic step();
    int nm;
    bit tick;
    @(posedge c50M);
    tick = (m_cyc % DIV) == DIV - 1;
    m_cyc++;
    if (tick) m_ticks++;
    nm = m_mode;
    case (m_mode)
      0: begin
        m_armed = 1;
        if (brakeActive && hardBrake) begin nm = 2; m_left = 2 * FC; m_armed = 0; end
        else if (brakeActive) nm = 1;
      end
      1: begin
        if (hardBrake && m_armed) begin nm = 2; m_left = 2 * FC; m_armed = 0; end
        else if (!brakeActive) nm = 4;
      end
      2, 3: begin
        if (m_ticks - m_entry >= FT) begin
          m_left--;
          if (m_left == 0) nm = brakeActive ? 1 : 0;
          else nm = (m_left % 2 == 0) ? 2 : 3;
        end
      end
      default: begin
        if (brakeActive) nm = 1;
        else if (m_ticks - m_entry >= HT) nm = 0;
      end
    endcase
    if (m_mode == 0 && nm == 0 && hazardActive) begin
      if (tick) m_haz++;
    end else begin
      m_haz = 0;
    end
    if (nm != m_mode) m_entry = m_ticks;
    m_mode  = nm;
    m_state = 3'(nm);
    m_flash = (nm == 2 || nm == 3);
    if (nm == 3)                   m_pwm = 10'h000;
    else if (nm != 0)              m_pwm = FULL;
    else if ((m_haz / HZT) % 2)    m_pwm = FULL;
    else                           m_pwm = headLightActive ? TAIL : 10'h000;
    #1;
  endtask

  task automatic test_reset();
    headLightActive = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge c50M);
    #1;
    checks++;
    if (PWMinput !== 10'h000 || lampState !== 3'd0 || flashing !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got %h/%b/%0d exp 000/0/0", PWMinput, flashing, lampState);
    end
    reset_n = 1'b1;
    model_reset();
    repeat (5) begin
      step();
      checks++;
      if ({PWMinput, flashing, lampState} !== {m_pwm, m_flash, m_state}) begin
        errors++;
        $display("FAIL reset_release t=%0t got %h/%b/%0d exp %h/%b/%0d", $time, PWMinput, flashing, lampState, m_pwm, m_flash, m_state);
      end
    end
    checks++;
    if (PWMinput !== TAIL || lampState !== 3'd0) begin
      errors++;
      $display("FAIL reset_tail got %h/%0d exp 01f/0", PWMinput, lampState);
    end
    $display("test_reset done");
  endtask

  task automatic test_brake_hold();
    int hold_cyc = 0;
    headLightActive = 1'b0;
    step();
    brakeActive = 1'b1;
    step();
    checks++;
    if (PWMinput !== FULL || lampState !== 3'd1) begin
      errors++;
      $display("FAIL brake_enter got %h/%0d exp 3ff/1", PWMinput, lampState);
    end
    brakeActive = 1'b0;
    repeat (40) begin
      step();
      if (lampState == 3'd4) hold_cyc++;
      checks++;
      if ({PWMinput, flashing, lampState} !== {m_pwm, m_flash, m_state}) begin
        errors++;
        $display("FAIL brake_hold t=%0t got %h/%b/%0d exp %h/%b/%0d", $time, PWMinput, flashing, lampState, m_pwm, m_flash, m_state);
      end
    end
    checks++;
    if (hold_cyc < (HT - 1) * DIV + 1 || hold_cyc > HT * DIV || PWMinput !== 10'h000 || lampState !== 3'd0) begin
      errors++;
      $display("FAIL hold_length got %0d cycles end %h/%0d exp 21..30 cycles end 000/0", hold_cyc, PWMinput, lampState);
    end
    $display("test_brake_hold done");
  endtask

  task automatic test_emergency_flash();
    int seq[$];
    int lens[$];
    int last, flash_cyc = 0;
    bit ok;
    last = lampState;
    brakeActive = 1'b1; hardBrake = 1'b1;
    repeat (130) begin
      step();
      if (flashing) flash_cyc++;
      if (lampState != last) begin seq.push_back(lampState); lens.push_back(1); last = lampState; end
      else if (lens.size() > 0) lens[lens.size() - 1]++;
      checks++;
      if ({PWMinput, flashing, lampState} !== {m_pwm, m_flash, m_state}) begin
        errors++;
        $display("FAIL eflash t=%0t got %h/%b/%0d exp %h/%b/%0d", $time, PWMinput, flashing, lampState, m_pwm, m_flash, m_state);
      end
    end
    ok = (seq.size() == 5);
    if (ok) ok = (seq[0] == 2 && seq[1] == 3 && seq[2] == 2 && seq[3] == 3 && seq[4] == 1
                  && lens[1] == FT * DIV && lens[2] == FT * DIV && lens[3] == FT * DIV);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL eflash_sequence got states %p lens %p exp states 2,3,2,3,1 inner lens 20", seq, lens);
    end
    checks++;
    if (flash_cyc < 2 * FC * FT * DIV - DIV + 1 || flash_cyc > 2 * FC * FT * DIV) begin
      errors++;
      $display("FAIL eflash_duration got %0d cycles exp 71..80", flash_cyc);
    end
    brakeActive = 1'b0; hardBrake = 1'b0;
    repeat (40) step();
    $display("test_emergency_flash done");
  endtask

  task automatic test_release_mid_flash();
    int hold_cyc = 0;
    brakeActive = 1'b1; hardBrake = 1'b1;
    repeat (25) step();
    brakeActive = 1'b0; hardBrake = 1'b0;
    repeat (80) begin
      step();
      if (lampState == 3'd4) hold_cyc++;
      checks++;
      if ({PWMinput, flashing, lampState} !== {m_pwm, m_flash, m_state}) begin
        errors++;
        $display("FAIL mid_release t=%0t got %h/%b/%0d exp %h/%b/%0d", $time, PWMinput, flashing, lampState, m_pwm, m_flash, m_state);
      end
    end
    checks++;
    if (hold_cyc != 0 || lampState !== 3'd0) begin
      errors++;
      $display("FAIL mid_release_nohold got hold %0d state %0d exp hold 0 state 0", hold_cyc, lampState);
    end
    $display("test_release_mid_flash done");
  endtask

  task automatic test_hazard();
    int toggles = 0;
    logic [9:0] prev;
    headLightActive = 1'b1; hazardActive = 1'b1;
    step();
    prev = PWMinput;
    repeat (100) begin
      step();
      if (PWMinput != prev) toggles++;
      prev = PWMinput;
      checks++;
      if ({PWMinput, flashing, lampState} !== {m_pwm, m_flash, m_state}) begin
        errors++;
        $display("FAIL hazard t=%0t got %h/%b/%0d exp %h/%b/%0d", $time, PWMinput, flashing, lampState, m_pwm, m_flash, m_state);
      end
    end
    checks++;
    if (toggles < 2) begin
      errors++;
      $display("FAIL hazard_toggles got %0d exp >=2", toggles);
    end
    repeat (15) step();
    brakeActive = 1'b1;
    step();
    checks++;
    if (PWMinput !== FULL || lampState !== 3'd1 || flashing !== 1'b0) begin
      errors++;
      $display("FAIL hazard_brake got %h/%b/%0d exp 3ff/0/1", PWMinput, flashing, lampState);
    end
    repeat (60) begin
      step();
      checks++;
      if ({PWMinput, flashing, lampState} !== {m_pwm, m_flash, m_state}) begin
        errors++;
        $display("FAIL hazard_braked t=%0t got %h/%b/%0d exp %h/%b/%0d", $time, PWMinput, flashing, lampState, m_pwm, m_flash, m_state);
      end
    end
    brakeActive = 1'b0; hazardActive = 1'b0; headLightActive = 1'b0;
    repeat (40) step();
    $display("test_hazard done");
  endtask

  task automatic test_reset_mid_flash();
    bit found = 0;
    int offs = 0;
    logic [2:0] prev;
    brakeActive = 1'b1; hardBrake = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (lampState == 3'd3) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_eflash_off got state %0d exp 3 within 100 cycles", lampState);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (PWMinput !== 10'h000 || lampState !== 3'd0 || flashing !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %h/%b/%0d exp 000/0/0", PWMinput, flashing, lampState);
    end
    @(posedge c50M);
    #1 reset_n = 1'b1;
    model_reset();
    prev = lampState;
    repeat (110) begin
      step();
      if (lampState == 3'd3 && prev != 3'd3) offs++;
      prev = lampState;
      checks++;
      if ({PWMinput, flashing, lampState} !== {m_pwm, m_flash, m_state}) begin
        errors++;
        $display("FAIL reset_restart t=%0t got %h/%b/%0d exp %h/%b/%0d", $time, PWMinput, flashing, lampState, m_pwm, m_flash, m_state);
      end
    end
    checks++;
    if (offs != FC || lampState !== 3'd1) begin
      errors++;
      $display("FAIL restart_pairs got %0d pairs state %0d exp %0d pairs state 1", offs, lampState, FC);
    end
    brakeActive = 1'b0; hardBrake = 1'b0;
    repeat (40) step();
    $display("test_reset_mid_flash done");
  endtask

  task automatic test_random();
    int n;
    int i = 0;
    while (i < 1500) begin
      brakeActive     = ($urandom_range(0, 99) < 55);
      hardBrake       = ($urandom_range(0, 99) < 35);
      headLightActive = 1'($urandom_range(0, 1));
      hazardActive    = ($urandom_range(0, 99) < 40);
      n = $urandom_range(1, 40);
      repeat (n) begin
        step();
        i++;
        checks++;
        if ({PWMinput, flashing, lampState} !== {m_pwm, m_flash, m_state}) begin
          errors++;
          $display("FAIL random t=%0t in b%b h%b l%b z%b got %h/%b/%0d exp %h/%b/%0d", $time, brakeActive, hardBrake, headLightActive, hazardActive, PWMinput, flashing, lampState, m_pwm, m_flash, m_state);
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_brake_hold();
    test_emergency_flash();
    test_release_mid_flash();
    test_hazard();
    test_reset_mid_flash();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
